face_stream_io: RTL and testbench
=================================

FACE_STREAM_IO -- requirements
Module: face_stream_io

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 30, width of each transferred word.
- N_WORDS, 9, number of sticker colour words per face.
- HDR_W, 6, width of the face-number header (HDR_W <= DATA_W).
- TIMEOUT_CYC, 0, maximum cycles spent waiting for the host in any handshake state; 0 disables the timeout.

REQ-002 The block SHALL have these ports:
- Clk  input  1  single clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- to_hw_sig  input  2  host command: 0 idle, 1 request word, 2 acknowledge, 3 start.
- ready  input  1  capture pipeline has a complete face.
- face_num  input  HDR_W  face identifier for the pending face.
- colors_flat  input  N_WORDS*DATA_W  colour words; word k occupies bits [k*DATA_W +: DATA_W], k = 0..N_WORDS-1.
- to_sw_port  output  DATA_W  word presented to the host.
- to_sw_sig  output  2  status to host: 0 idle/acked, 1 word valid, 2 capturing, 3 init/error.
- face_done  output  1  one-cycle pulse when a face transfer completes.
- busy  output  1  high in every state except IDLE and ERROR.
- err  output  1  high while in ERROR.

Function
REQ-003 The state machine SHALL have the states IDLE, CAPTURE, ARMED, SEND, ACKED, DONE and ERROR, held in registers; all outputs SHALL be decoded from the registered state and index only (Moore).
REQ-004 IDLE: go to CAPTURE when to_hw_sig==3; otherwise remain.
REQ-005 CAPTURE: when ready==1, go to ARMED and, on the same edge, latch face_num and colors_flat into a snapshot buffer and clear the word index idx.
REQ-006 ARMED: go to SEND when to_hw_sig==1.
REQ-007 SEND: go to ACKED when to_hw_sig==2.
REQ-008 ACKED: if idx==N_WORDS, go to DONE; else if to_hw_sig==1, increment idx and go to SEND.
REQ-009 DONE: go to IDLE after exactly one cycle.
REQ-010 idx SHALL be $clog2(N_WORDS+1) bits wide and SHALL never exceed N_WORDS.
REQ-011 In SEND, to_sw_port SHALL carry:
- when idx==0, the latched face_num, zero-extended to DATA_W;
- when idx==k (k>=1), latched colour word k-1.
In every other state, to_sw_port SHALL be 0.
REQ-012 to_sw_sig per state: IDLE 0, CAPTURE 2, ARMED 0, SEND 1, ACKED 0, DONE 0, ERROR 3.
REQ-013 face_done SHALL be 1 only in DONE.
REQ-014 Changes on face_num, colors_flat or ready after the snapshot edge SHALL NOT affect words transmitted for that face.
REQ-015 Timeout counter (only when TIMEOUT_CYC>0):
- clears on every state change;
- increments each cycle spent in ARMED, SEND or ACKED;
- when it reaches TIMEOUT_CYC, the next state SHALL be ERROR;
- timeout has priority over any simultaneous host transition.
REQ-016 CAPTURE SHALL NOT time out: the camera may take arbitrarily long.
REQ-017 ERROR: remain while to_hw_sig!=0; go to IDLE when to_hw_sig==0.
REQ-018 Host abort: to_hw_sig==3 received in ARMED, SEND or ACKED SHALL restart the transfer by going to CAPTURE, discarding the snapshot.
REQ-019 Priority in all states: timeout > abort (to_hw_sig==3) > normal transition.
REQ-020 Host codes not listed for the current state SHALL hold the state (no spurious advance).
REQ-021 A total of N_WORDS+1 words SHALL be transferred per face: the header plus N_WORDS colours.

Reset
REQ-022 While Reset==0, regardless of Clk:
- state SHALL be IDLE;
- idx, the timeout counter and the snapshot buffer SHALL be 0;
- outputs SHALL be to_sw_port=0, to_sw_sig=0, face_done=0, busy=0, err=0.
REQ-023 Reset assertion mid-transfer SHALL abandon the transfer immediately, with no face_done pulse.
REQ-024 Reset deassertion SHALL take effect on the first Clk edge after release; no host command is required to leave IDLE.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Default parameters, full handshake, face_num=6'd5, colour words k+1 -> host sees 5,1,2,...,9 in order with to_sw_sig=1 during each; face_done pulses exactly one cycle after the 10th acknowledge; to_sw_sig returns to 0.
- Change colors_flat to all-ones one cycle after ready -> transmitted words remain 1..9.
- TIMEOUT_CYC=16, host stalls in SEND -> err=1 and to_sw_sig=3 on the 17th cycle; to_hw_sig=0 returns the block to IDLE with busy=0.
- to_hw_sig=3 issued in ACKED after word 4 -> block goes to CAPTURE (to_sw_sig=2); the next transfer starts again at header word 0.
- Reset pulled low while in SEND idx=3 -> all outputs 0 asynchronously; after release, state is IDLE and face_done was never asserted.
- N_WORDS=4, DATA_W=8 -> exactly 5 words transferred, idx never exceeds 4.

Source files
------------

// File: rtl/face_stream_io.sv
// Streams one captured face (header word plus N_WORDS colour words) to a host
// over a request/acknowledge word handshake, with optional host-stall timeout.
module face_stream_io #(
   parameter int DATA_W      = 30,
   parameter int N_WORDS     = 9,
   parameter int HDR_W       = 6,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [1:0]                to_hw_sig,
   input  logic                      ready,
   input  logic [HDR_W-1:0]          face_num,
   input  logic [N_WORDS*DATA_W-1:0] colors_flat,
   output logic [DATA_W-1:0]         to_sw_port,
   output logic [1:0]                to_sw_sig,
   output logic                      face_done,
   output logic                      busy,
   output logic                      err
);

   localparam int IDX_W = $clog2(N_WORDS + 1);
   localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   localparam logic [1:0] CMD_REQ   = 2'd1;
   localparam logic [1:0] CMD_ACK   = 2'd2;
   localparam logic [1:0] CMD_START = 2'd3;
   localparam logic [1:0] CMD_IDLE  = 2'd0;

   localparam logic [1:0] SIG_IDLE  = 2'd0;
   localparam logic [1:0] SIG_VALID = 2'd1;
   localparam logic [1:0] SIG_CAPT  = 2'd2;
   localparam logic [1:0] SIG_ERR   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_ARMED,
      S_SEND,
      S_ACKED,
      S_DONE,
      S_ERROR
   } state_e;

   state_e                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [TMO_W-1:0]            tmo_q, tmo_d;
   logic [HDR_W-1:0]            hdr_q;
   logic [N_WORDS*DATA_W-1:0]   snap_q;
   logic                        snap_load;
   logic                        in_handshake;
   logic                        tmo_hit;

   assign in_handshake = (state_q == S_ARMED) || (state_q == S_SEND) || (state_q == S_ACKED);
   // The counter reaching TIMEOUT_CYC on this edge is what forces ERROR.
   assign tmo_hit      = (TIMEOUT_CYC > 0) && in_handshake &&
                         (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   // NOTE: every output of this block gets a default first, so no path can
   // leave a variable unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      tmo_d     = tmo_q;
      snap_load = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (to_hw_sig == CMD_START) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (ready) begin
               state_d   = S_ARMED;
               snap_load = 1'b1;
               idx_d     = '0;
            end
         end
         S_ARMED: begin
            if (to_hw_sig == CMD_START)    state_d = S_CAPTURE;
            else if (to_hw_sig == CMD_REQ) state_d = S_SEND;
         end
         S_SEND: begin
            if (to_hw_sig == CMD_START)    state_d = S_CAPTURE;
            else if (to_hw_sig == CMD_ACK) state_d = S_ACKED;
         end
         S_ACKED: begin
            if (to_hw_sig == CMD_START) begin
               state_d = S_CAPTURE;
            end else if (idx_q == IDX_W'(N_WORDS)) begin
               state_d = S_DONE;
            end else if (to_hw_sig == CMD_REQ) begin
               state_d = S_SEND;
               idx_d   = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_ERROR: begin
            if (to_hw_sig == CMD_IDLE) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (tmo_hit) begin
         state_d = S_ERROR;
         idx_d   = idx_q;
      end

      if (state_d != state_q) tmo_d = '0;
      else if ((TIMEOUT_CYC > 0) && in_handshake) tmo_d = tmo_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         // NOTE: the snapshot buffer is cleared on reset as well, so no word
         // from an abandoned transfer can ever reappear on the port.
         hdr_q   <= '0;
         snap_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         if (snap_load) begin
            hdr_q  <= face_num;
            snap_q <= colors_flat;
         end
      end
   end

   // Moore outputs: decoded from registered state and index only.
   always_comb begin
      to_sw_port = '0;
      to_sw_sig  = SIG_IDLE;
      face_done  = 1'b0;
      busy       = 1'b0;
      err        = 1'b0;

      case (state_q)
         S_CAPTURE: begin
            to_sw_sig = SIG_CAPT;
            busy      = 1'b1;
         end
         S_ARMED: begin
            busy = 1'b1;
         end
         S_SEND: begin
            to_sw_sig = SIG_VALID;
            busy      = 1'b1;
            if (idx_q == '0) to_sw_port = DATA_W'(hdr_q);
            else to_sw_port = DATA_W'(snap_q >> ((int'(idx_q) - 1) * DATA_W));
         end
         S_ACKED: begin
            busy = 1'b1;
         end
         S_DONE: begin
            face_done = 1'b1;
            busy      = 1'b1;
         end
         S_ERROR: begin
            to_sw_sig = SIG_ERR;
            err       = 1'b1;
         end
         default: begin
            to_sw_sig = SIG_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_face_stream_io.sv
// Scoreboard bench for face_stream_io: three instances (defaults, 16-cycle
// timeout, 4x8-bit words) driven by a host model; a monitor checks each word.
module tb_face_stream_io;

   typedef struct {
      int          d;
      logic [29:0] w;
   } exp_t;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   always #5 Clk = ~Clk;

   logic [1:0]   hw   [3];
   logic         rdy  [3];
   logic [5:0]   fnum [3];
   logic [269:0] col  [3];
   logic [29:0]  port [3];
   logic [1:0]   sig  [3];
   logic         done [3];
   logic         busy [3];
   logic         err  [3];
   logic [29:0]  p0, p1;
   logic [7:0]   p2;

   int           checks = 0;
   int           errors = 0;
   exp_t         sb_q[$];
   int           done_cnt [3];
   int           exp_done [3];
   logic [1:0]   prev_sig [3];
   int           idx2_max = 0;

   face_stream_io dut0 (
      .Clk(Clk), .Reset(Reset), .to_hw_sig(hw[0]), .ready(rdy[0]), .face_num(fnum[0]),
      .colors_flat(col[0]), .to_sw_port(p0), .to_sw_sig(sig[0]), .face_done(done[0]),
      .busy(busy[0]), .err(err[0]));

   face_stream_io #(.TIMEOUT_CYC(16)) dut1 (
      .Clk(Clk), .Reset(Reset), .to_hw_sig(hw[1]), .ready(rdy[1]), .face_num(fnum[1]),
      .colors_flat(col[1]), .to_sw_port(p1), .to_sw_sig(sig[1]), .face_done(done[1]),
      .busy(busy[1]), .err(err[1]));

   face_stream_io #(.DATA_W(8), .N_WORDS(4)) dut2 (
      .Clk(Clk), .Reset(Reset), .to_hw_sig(hw[2]), .ready(rdy[2]), .face_num(fnum[2]),
      .colors_flat(col[2][31:0]), .to_sw_port(p2), .to_sw_sig(sig[2]), .face_done(done[2]),
      .busy(busy[2]), .err(err[2]));

   assign port[0] = p0;
   assign port[1] = p1;
   assign port[2] = {22'b0, p2};

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Monitor: pops one expected word each time a DUT starts presenting a word.
   always @(negedge Clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (sig[d] == 2'd1 && prev_sig[d] != 2'd1) begin
            if (sb_q.size() > 0) e = sb_q.pop_front();
            else begin
               e.d = -1;
               e.w = '1;
            end
            check("sb_word_dut", 32'(d), 32'(e.d));
            check("sb_word", 32'(port[d]), 32'(e.w));
         end
         if (sig[d] != 2'd1) check("port_zero", 32'(port[d]), 32'd0);
         if (done[d]) done_cnt[d]++;
         prev_sig[d] = sig[d];
      end
      if (int'(dut2.idx_q) > idx2_max) idx2_max = int'(dut2.idx_q);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [269:0] pack_cols(input int nw, input int dw, input logic [29:0] w [9]);
      logic [269:0] c = '0;
      logic [63:0]  mask = (64'(1) << dw) - 64'(1);
      for (int k = 0; k < nw; k++) c = c | (270'(64'(w[k]) & mask) << (k * dw));
      return c;
   endfunction

   // Reference: header zero-extended, then colour word k is field k of the bus.
   task automatic push_face(input int d, input int nw, input int dw, input logic [5:0] f,
                            input logic [269:0] c);
      exp_t         e;
      logic [269:0] mask = (270'(1) << dw) - 270'(1);
      e.d = d;
      e.w = 30'(f);
      sb_q.push_back(e);
      for (int k = 0; k < nw; k++) begin
         e.w = 30'((c >> (k * dw)) & mask);
         sb_q.push_back(e);
      end
   endtask

   task automatic flush(input int d);
      exp_t keep[$];
      foreach (sb_q[i]) if (sb_q[i].d != d) keep.push_back(sb_q[i]);
      sb_q = keep;
   endtask

   task automatic wait_sig(input int d, input logic [1:0] want, input string nm);
      int n = 0;
      @(negedge Clk);
      while (sig[d] !== want && n < 60) begin
         @(negedge Clk);
         n++;
      end
      check(nm, 32'(sig[d]), 32'(want));
   endtask

   // Called at a negedge while the DUT is in CAPTURE.
   task automatic capture_face(input int d, input int nw, input int dw, input logic [5:0] f,
                               input logic [269:0] c, input int cap_wait, input bit upset);
      hw[d] = 2'd0;
      repeat (cap_wait) @(negedge Clk);
      check("still_capturing", 32'(sig[d]), 32'd2);
      fnum[d] = f;
      col[d]  = c;
      rdy[d]  = 1'b1;
      @(negedge Clk);
      check("armed_sig", 32'(sig[d]), 32'd0);
      check("armed_busy", 32'(busy[d]), 32'd1);
      push_face(d, nw, dw, f, c);
      rdy[d] = 1'b0;
      if (upset) begin
         col[d]  = '1;
         fnum[d] = ~f;
         rdy[d]  = 1'b1;
      end else begin
         col[d]  = {9{30'($urandom)}};
         fnum[d] = 6'($urandom);
      end
   endtask

   task automatic start_face(input int d, input int nw, input int dw, input logic [5:0] f,
                             input logic [269:0] c, input int cap_wait, input bit upset);
      hw[d] = 2'd3;
      wait_sig(d, 2'd2, "capture_sig");
      capture_face(d, nw, dw, f, c, cap_wait, upset);
   endtask

   task automatic send_words(input int d, input int count);
      for (int i = 0; i < count; i++) begin
         hw[d] = 2'd1;
         wait_sig(d, 2'd1, "word_valid");
         hw[d] = 2'd2;
         wait_sig(d, 2'd0, "word_acked");
      end
   endtask

   // Called at the negedge after the final acknowledge has been taken.
   task automatic finish_face(input int d);
      hw[d] = 2'd0;
      @(negedge Clk);
      check("done_pulse", 32'(done[d]), 32'd1);
      check("done_sig", 32'(sig[d]), 32'd0);
      @(negedge Clk);
      check("done_one_cycle", 32'(done[d]), 32'd0);
      check("idle_busy", 32'(busy[d]), 32'd0);
      check("idle_sig", 32'(sig[d]), 32'd0);
      exp_done[d]++;
      rdy[d] = 1'b0;
   endtask

   task automatic check_quiet(input int d, input string nm);
      check({nm, "_port"}, 32'(port[d]), 32'd0);
      check({nm, "_sig"}, 32'(sig[d]), 32'd0);
      check({nm, "_done"}, 32'(done[d]), 32'd0);
      check({nm, "_busy"}, 32'(busy[d]), 32'd0);
      check({nm, "_err"}, 32'(err[d]), 32'd0);
   endtask

   initial begin
      logic [29:0]  w [9];
      logic [269:0] c;
      int           dc;

      for (int d = 0; d < 3; d++) begin
         hw[d] = 2'd0; rdy[d] = 1'b0; fnum[d] = '0; col[d] = '0;
         done_cnt[d] = 0; exp_done[d] = 0; prev_sig[d] = 2'd0;
      end

      #2 Reset = 1'b0;
      #1 for (int d = 0; d < 3; d++) check_quiet(d, "reset");
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      for (int d = 0; d < 3; d++) check_quiet(d, "post_reset");

      // Directed: header 5, colours 1..9.
      for (int k = 0; k < 9; k++) w[k] = 30'(k + 1);
      c = pack_cols(9, 30, w);
      start_face(0, 9, 30, 6'd5, c, 0, 1'b0);
      send_words(0, 10);
      finish_face(0);

      // Snapshot isolation: bus goes all-ones right after the snapshot edge.
      start_face(0, 9, 30, 6'd5, c, 2, 1'b1);
      send_words(0, 10);
      finish_face(0);

      // Random faces, including an ACK held in ARMED that must not advance.
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 9; k++) w[k] = 30'($urandom);
         start_face(0, 9, 30, 6'($urandom), pack_cols(9, 30, w), $urandom_range(0, 5), 1'b0);
         hw[0] = 2'd2;
         repeat (3) @(negedge Clk);
         check("armed_hold", 32'(sig[0]), 32'd0);
         check("armed_hold_busy", 32'(busy[0]), 32'd1);
         send_words(0, 10);
         finish_face(0);
      end

      // Timeout disabled: a long stall in SEND never errors.
      for (int k = 0; k < 9; k++) w[k] = 30'($urandom);
      start_face(0, 9, 30, 6'($urandom), pack_cols(9, 30, w), 1, 1'b0);
      hw[0] = 2'd1;
      wait_sig(0, 2'd1, "stall_send");
      repeat (40) @(negedge Clk);
      check("no_timeout_sig", 32'(sig[0]), 32'd1);
      check("no_timeout_err", 32'(err[0]), 32'd0);
      hw[0] = 2'd2;
      wait_sig(0, 2'd0, "stall_acked");
      send_words(0, 9);
      finish_face(0);

      // Host abort in ACKED after word 4, then a fresh transfer from the header.
      for (int k = 0; k < 9; k++) w[k] = 30'($urandom);
      start_face(0, 9, 30, 6'($urandom), pack_cols(9, 30, w), 0, 1'b0);
      send_words(0, 5);
      hw[0] = 2'd3;
      @(negedge Clk);
      check("abort_sig", 32'(sig[0]), 32'd2);
      check("abort_busy", 32'(busy[0]), 32'd1);
      flush(0);
      for (int k = 0; k < 9; k++) w[k] = 30'($urandom);
      capture_face(0, 9, 30, 6'($urandom), pack_cols(9, 30, w), 1, 1'b0);
      send_words(0, 10);
      finish_face(0);

      // Timeout: long capture is fine, host then stalls in SEND.
      for (int k = 0; k < 9; k++) w[k] = 30'($urandom);
      start_face(1, 9, 30, 6'($urandom), pack_cols(9, 30, w), 40, 1'b0);
      hw[1] = 2'd1;
      wait_sig(1, 2'd1, "tmo_send");
      repeat (15) @(negedge Clk);
      check("tmo_cycle16_sig", 32'(sig[1]), 32'd1);
      @(negedge Clk);
      check("tmo_cycle17_err", 32'(err[1]), 32'd1);
      check("tmo_cycle17_sig", 32'(sig[1]), 32'd3);
      check("tmo_busy", 32'(busy[1]), 32'd0);
      @(negedge Clk);
      check("error_holds", 32'(err[1]), 32'd1);
      hw[1] = 2'd0;
      @(negedge Clk);
      check_quiet(1, "error_exit");
      flush(1);

      // Reset mid-transfer in SEND with idx 3.
      for (int k = 0; k < 9; k++) w[k] = 30'(k + 1);
      start_face(0, 9, 30, 6'd5, pack_cols(9, 30, w), 0, 1'b0);
      send_words(0, 3);
      hw[0] = 2'd1;
      wait_sig(0, 2'd1, "send_idx3");
      check("send_idx3_word", 32'(port[0]), 32'd3);
      dc = done_cnt[0];
      #2 Reset = 1'b0;
      #1 check_quiet(0, "async_reset");
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check_quiet(0, "reset_release");
      check("no_done_on_reset", 32'(done_cnt[0]), 32'(dc));
      flush(0);
      hw[0] = 2'd0;

      // Small instance: 5 words per face.
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < 9; k++) w[k] = 30'($urandom);
         start_face(2, 4, 8, 6'($urandom), pack_cols(4, 8, w), $urandom_range(0, 3), 1'b0);
         send_words(2, 5);
         finish_face(2);
      end

      repeat (3) @(negedge Clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      for (int d = 0; d < 3; d++) check("done_count", 32'(done_cnt[d]), 32'(exp_done[d]));
      check("small_idx_max", 32'(idx2_max), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
